// File: rtl/dmem_responder.sv
// Data-memory responder: target end of the memory-stage load/store interface.
// One outstanding request, programmable wait-state latency, byte/half/word
// loads and stores against an internal 32-bit word array.
// Optional feature macro: DMEM_ERR_EN (access-fault reporting on rsp_err_o).
// Without it, addresses are force-aligned, the index wraps and rsp_err_o is 0.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [1:0] SZ_B     = 2'd0;
  localparam logic [1:0] SZ_H     = 2'd1;
  localparam logic [1:0] SZ_W     = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  w_access;
  logic                  w_accept;
  logic                  w_idle;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH_WORDS];

  // Access fields: taken straight from the request when the access happens on
  // the accept edge (LATENCY==1), otherwise from the latched copy.
  logic                  w_a_write;
  logic [2:0]            w_a_funct3;
  logic [ADDR_WIDTH-1:0] w_a_addr;
  logic [31:0]           w_a_wdata;
  logic [1:0]            w_size;
  logic                  w_fault;
  logic [1:0]            w_lane;
  logic [IDX_W-1:0]      w_idx;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load;
  logic                  w_sext;
  logic [3:0]            w_be;
  logic [31:0]           w_wd_lane;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = req_valid_i & w_idle;
  assign w_a_write  = w_idle ? req_write_i  : r_write;
  assign w_a_funct3 = w_idle ? req_funct3_i : r_funct3;
  assign w_a_addr   = w_idle ? req_addr_i   : r_addr;
  assign w_a_wdata  = w_idle ? req_wdata_i  : r_wdata;
  assign w_idx      = w_a_addr[IDX_W+1:2];
  assign w_sext     = ~w_a_funct3[2];

`ifdef DMEM_ERR_EN
  logic w_misal;
  logic w_oor;
  assign w_misal = ((w_size == SZ_H) && w_a_addr[0]) ||
                   ((w_size == SZ_W) && (w_a_addr[1:0] != 2'b00));
  assign w_oor   = |(w_a_addr >> (IDX_W + 2));
`endif

  // Decode access size and fault; illegal funct3 falls back to a word access.
  always_comb begin
    w_size  = SZ_W;
    w_fault = 1'b0;
    case (w_a_funct3)
      3'b000:  w_size = SZ_B;
      3'b001:  w_size = SZ_H;
      3'b010:  w_size = SZ_W;
      3'b100:  begin
        w_size = w_a_write ? SZ_W : SZ_B;
`ifdef DMEM_ERR_EN
        w_fault = w_a_write;
`endif
      end
      3'b101:  begin
        w_size = w_a_write ? SZ_W : SZ_H;
`ifdef DMEM_ERR_EN
        w_fault = w_a_write;
`endif
      end
      default: begin
        w_size = SZ_W;
`ifdef DMEM_ERR_EN
        w_fault = 1'b1;
`endif
      end
    endcase
`ifdef DMEM_ERR_EN
    if (w_misal || w_oor) begin
      w_fault = 1'b1;
    end else begin
      w_fault = w_fault;
    end
`endif
  end

  // Lane selection with forced alignment, plus load extraction and extension.
  always_comb begin
    w_lane    = w_a_addr[1:0];
    w_load    = 32'd0;
    w_rd_word = r_mem[w_idx];
    case (w_size)
      SZ_B:    w_lane = w_a_addr[1:0];
      SZ_H:    w_lane = {w_a_addr[1], 1'b0};
      default: w_lane = 2'b00;
    endcase
    w_shifted = w_rd_word >> {w_lane, 3'b000};
    case (w_size)
      SZ_B:    w_load = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    w_load = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_rd_word;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    w_be      = 4'b0000;
    w_wd_lane = w_a_wdata;
    case (w_size)
      SZ_B: begin
        w_be      = 4'b0001 << w_lane;
        w_wd_lane = {4{w_a_wdata[7:0]}};
      end
      SZ_H: begin
        w_be      = 4'b0011 << w_lane;
        w_wd_lane = {2{w_a_wdata[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_wd_lane = w_a_wdata;
      end
    endcase
  end

  // Next-state logic; the access happens on the edge that enters RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, request latch and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      if (w_accept) begin
        r_write  <= req_write_i;
        r_funct3 <= req_funct3_i;
        r_addr   <= req_addr_i;
        r_wdata  <= req_wdata_i;
      end
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rdata     <= (w_a_write || w_fault) ? 32'd0 : w_load;
        r_err       <= w_fault;
      end else if ((r_state == S_RESP) && rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Array write with byte enables; never during reset, never for a fault.
  always_ff @(posedge clk) begin
    if (rst_n && w_access && w_a_write && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wd_lane[8*b +: 8];
        end
      end
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
`ifdef DMEM_ERR_EN
  assign rsp_err_o   = r_err;
`else
  assign rsp_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: two instances (LATENCY 1 and 3), directed
// cases plus randomized traffic checked against a byte-level memory model.
module tb_dmem_responder;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_err    [2];

  logic [31:0] m_mem [2][1024];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_funct3_i(req_funct3[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]));

  dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_funct3_i(req_funct3[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Reference: size from funct3, fault rules, then byte-wise memory update/read.
  function automatic void model(input int d, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int          size;
    int          ill;
    logic [31:0] a;
    int          idx;
    int          lane;
    logic [31:0] w;
    ill = 0;
    if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: begin size = 4; ill = 1; end
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default: begin size = 4; ill = 1; end
      endcase
    end
    rd = 32'd0;
    er = 1'b0;
`ifdef DMEM_ERR_EN
    if (ill != 0 || (addr % size) != 0 || addr >= 32'd4096) begin
      er = 1'b1;
      return;
    end
`endif
    a    = addr - (addr % size);
    idx  = int'((a / 4) % 1024);
    lane = int'(a % 4);
    w    = m_mem[d][idx];
    if (wr) begin
      for (int k = 0; k < size; k++) w[8*(lane+k) +: 8] = wd[8*k +: 8];
      m_mem[d][idx] = w;
    end else begin
      rd = w >> (8 * lane);
      if (size == 1) begin
        rd = rd & 32'h0000_00FF;
        if (f3 == 3'd0 && rd[7]) rd = rd | 32'hFFFF_FF00;
      end else if (size == 2) begin
        rd = rd & 32'h0000_FFFF;
        if (f3 == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
      end
    end
  endfunction

  // One complete request/response on instance d, with 'stall' cycles of rsp_ready low.
  task automatic xact(input int d, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          n;
    for (int i = 0; i < 10 && !req_ready[d]; i++) begin
      @(posedge clk); #1;
    end
    check_eq("req_ready_idle", 32'(req_ready[d]), 32'd1);
    model(d, wr, f3, addr, wd, exp_rd, exp_er);
    req_write[d]  = wr;
    req_funct3[d] = f3;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    req_valid[d]  = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 40) begin
      check_eq("busy_ready", 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 32'(n), 32'((d == 0) ? LAT0 : LAT1));
    check_eq("rdata", rsp_rdata[d], exp_rd);
    check_eq("err", 32'(rsp_err[d]), 32'(exp_er));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check_eq("hold_rdata", rsp_rdata[d], exp_rd);
      check_eq("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check_eq("rsp_drop", 32'(rsp_valid[d]), 32'd0);
    check_eq("ready_back", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    int          d;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_funct3[i] = 3'd0;
      req_addr[i] = 32'd0; req_wdata[i] = 32'd0; rsp_ready[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_valid", 32'(rsp_valid[i]), 32'd0);
      check_eq("rst_ready", 32'(req_ready[i]), 32'd1);
      check_eq("rst_rdata", rsp_rdata[i], 32'd0);
      check_eq("rst_err", 32'(rsp_err[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Give the low words of both arrays known contents.
    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 32; w++) xact(i, 1'b1, 3'b010, 32'(w * 4), $urandom, 0, rd, er);

    // Word store then load, single-cycle latency.
    xact(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    xact(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd, er);
    check_eq("t1_lw", rd, 32'hDEADBEEF);
    check_eq("t1_err", 32'(er), 32'd0);

    // Byte store into the middle of a word.
    xact(0, 1'b1, 3'b010, 32'h20, 32'h11223344, 0, rd, er);
    xact(0, 1'b1, 3'b000, 32'h22, 32'h000000AA, 0, rd, er);
    xact(0, 1'b0, 3'b010, 32'h20, 32'd0, 0, rd, er);
    check_eq("t2_lw", rd, 32'h11AA3344);

    // Sign and zero extension.
    xact(0, 1'b1, 3'b010, 32'h30, 32'h00008080, 0, rd, er);
    xact(0, 1'b0, 3'b000, 32'h30, 32'd0, 0, rd, er);
    check_eq("t3_lb", rd, 32'hFFFFFF80);
    xact(0, 1'b0, 3'b100, 32'h30, 32'd0, 0, rd, er);
    check_eq("t3_lbu", rd, 32'h00000080);
    xact(0, 1'b0, 3'b001, 32'h30, 32'd0, 0, rd, er);
    check_eq("t3_lh", rd, 32'hFFFF8080);
    xact(0, 1'b0, 3'b101, 32'h30, 32'd0, 0, rd, er);
    check_eq("t3_lhu", rd, 32'h00008080);

    // Longer latency with the initiator stalling the response.
    xact(1, 1'b1, 3'b010, 32'h44, 32'hCAFEF00D, 4, rd, er);
    xact(1, 1'b0, 3'b010, 32'h44, 32'd0, 4, rd, er);
    check_eq("t4_lw", rd, 32'hCAFEF00D);

    // Misaligned and out-of-range word accesses.
    xact(0, 1'b0, 3'b010, 32'h2, 32'd0, 0, rd, er);
`ifdef DMEM_ERR_EN
    check_eq("t5_err", 32'(er), 32'd1);
    check_eq("t5_rd", rd, 32'd0);
`else
    check_eq("t5_err", 32'(er), 32'd0);
`endif
    xact(0, 1'b1, 3'b010, 32'h1000, 32'h5A5A5A5A, 0, rd, er);
    xact(0, 1'b0, 3'b010, 32'h0, 32'd0, 0, rd, er);
`ifndef DMEM_ERR_EN
    check_eq("t5_wrap", rd, 32'h5A5A5A5A);
`endif

    // Reset while a store sits in WAIT: the store must be dropped.
    xact(1, 1'b1, 3'b010, 32'h40, 32'h0BADF00D, 0, rd, er);
    req_write[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = 32'h40;
    req_wdata[1] = 32'h12345678; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(rsp_valid[1]), 32'd0);
    check_eq("t6_rst_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    check_eq("t6_rst_valid2", 32'(rsp_valid[1]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(1, 1'b0, 3'b010, 32'h40, 32'd0, 0, rd, er);
    check_eq("t6_keep", rd, 32'h0BADF00D);

    // Randomized mix over both instances.
    for (int t = 0; t < 300; t++) begin
      d    = int'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr = addr + 32'h1000;
      xact(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
           int'($urandom_range(0, 2)), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
